// File: rtl/ex2_lsu_if.sv
// Data-memory request/acknowledge bus between the EX2 load/store unit and
// the single-port data memory.
interface ex2_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/ex2_lsu.sv
// EX2-stage load/store unit: serialises up to two lane memory ops (lane1
// first) onto one memory bus, holds the pipeline while working and presents
// formatted load data plus per-lane faults for one DONE cycle.
//
// state | meaning
// IDLE  | waiting for a mem op in either lane
// ACC1  | serving lane1 access
// ACC2  | serving lane2 access
// DONE  | results valid, pipeline released for this cycle
module ex2_lsu #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] EX2_in_instr1,
  input  logic [31:0] EX2_in_instr2,
  input  logic [31:0] EX2_in_alu_result1,
  input  logic [31:0] EX2_in_alu_result2,
  input  logic [31:0] EX2_in_read_data2_1,
  input  logic [31:0] EX2_in_read_data2_2,
  ex2_lsu_if.master   mem,
  output logic        EX2_lsu_busy,
  output logic [31:0] EX2_out_ld_data1,
  output logic [31:0] EX2_out_ld_data2,
  output logic        EX2_out_misalign1,
  output logic        EX2_out_misalign2,
  output logic        EX2_out_bus_err1,
  output logic        EX2_out_bus_err2
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] cnt;

  logic        mem1, mem2;
  logic [6:0]  cur_op;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr, cur_data;
  logic        cur_load, cur_misal, to_hit, adv;
  logic [31:0] shifted, ld_fmt;

  assign mem1 = (EX2_in_instr1[6:0] == OP_LOAD) || (EX2_in_instr1[6:0] == OP_STORE);
  assign mem2 = (EX2_in_instr2[6:0] == OP_LOAD) || (EX2_in_instr2[6:0] == OP_STORE);

  // Select the lane being served; lane mix is assumed stable while busy.
  always_comb begin
    if (state == ACC2) begin
      cur_op   = EX2_in_instr2[6:0];
      cur_f3   = EX2_in_instr2[14:12];
      cur_addr = EX2_in_alu_result2;
      cur_data = EX2_in_read_data2_2;
    end else begin
      cur_op   = EX2_in_instr1[6:0];
      cur_f3   = EX2_in_instr1[14:12];
      cur_addr = EX2_in_alu_result1;
      cur_data = EX2_in_read_data2_1;
    end
  end

  assign cur_load  = (cur_op == OP_LOAD);
  assign cur_misal = (cur_f3[1] && (cur_addr[1:0] != 2'b00)) ||
                     ((cur_f3[1:0] == 2'b01) && cur_addr[0]);
  assign to_hit    = (TIMEOUT != 0) && (cnt == TO_LAST);

  // Extract and extend the addressed byte/half from the returned word.
  always_comb begin
    shifted = mem.mem_rdata >> {cur_addr[1:0], 3'b000};
    case (cur_f3)
      3'b000:  ld_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_fmt = {24'b0, shifted[7:0]};
      3'b101:  ld_fmt = {16'b0, shifted[15:0]};
      default: ld_fmt = mem.mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, bus drive and pipeline hold.
  always_comb begin
    state_nxt     = state;
    EX2_lsu_busy  = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = 32'b0;
    mem.mem_wdata = 32'b0;
    mem.mem_wstrb = 4'b0;
    adv           = 1'b0;
    case (state)
      IDLE: begin
        if (mem1 || mem2) begin
          EX2_lsu_busy = rstn;
          state_nxt    = mem1 ? ACC1 : ACC2;
        end
      end
      ACC1, ACC2: begin
        EX2_lsu_busy = 1'b1;
        mem.mem_we   = ~cur_load;
        mem.mem_addr = {cur_addr[31:2], 2'b00};
        case (cur_f3[1:0])
          2'b00: begin
            mem.mem_wstrb = 4'b0001 << cur_addr[1:0];
            mem.mem_wdata = {4{cur_data[7:0]}};
          end
          2'b01: begin
            mem.mem_wstrb = 4'b0011 << cur_addr[1:0];
            mem.mem_wdata = {2{cur_data[15:0]}};
          end
          default: begin
            mem.mem_wstrb = 4'b1111;
            mem.mem_wdata = cur_data;
          end
        endcase
        if (cur_misal) begin
          adv = 1'b1;
        end else begin
          mem.mem_req = 1'b1;
          adv         = mem.mem_ack || to_hit;
        end
        if (adv) state_nxt = ((state == ACC1) && mem2) ? ACC2 : DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Wait-cycle counter, restarted on every state change.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                              cnt <= '0;
    else if (state != state_nxt)            cnt <= '0;
    else if (mem.mem_req && !mem.mem_ack)   cnt <= cnt + 1'b1;
  end

  // Per-lane result registers: cleared on entry to an access, updated when
  // the lane's access resolves (ack, misalign or timeout).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      EX2_out_ld_data1  <= '0;
      EX2_out_ld_data2  <= '0;
      EX2_out_misalign1 <= 1'b0;
      EX2_out_misalign2 <= 1'b0;
      EX2_out_bus_err1  <= 1'b0;
      EX2_out_bus_err2  <= 1'b0;
    end else if (state == IDLE && state_nxt != IDLE) begin
      EX2_out_ld_data1  <= '0;
      EX2_out_ld_data2  <= '0;
      EX2_out_misalign1 <= 1'b0;
      EX2_out_misalign2 <= 1'b0;
      EX2_out_bus_err1  <= 1'b0;
      EX2_out_bus_err2  <= 1'b0;
    end else if (adv) begin
      if (state == ACC1) begin
        EX2_out_ld_data1  <= (!cur_misal && mem.mem_ack && cur_load) ? ld_fmt : 32'b0;
        EX2_out_misalign1 <= cur_misal;
        EX2_out_bus_err1  <= !cur_misal && !mem.mem_ack;
      end else begin
        EX2_out_ld_data2  <= (!cur_misal && mem.mem_ack && cur_load) ? ld_fmt : 32'b0;
        EX2_out_misalign2 <= cur_misal;
        EX2_out_bus_err2  <= !cur_misal && !mem.mem_ack;
      end
    end
  end

endmodule

// File: tb/tb_ex2_lsu.sv
// Directed bench for ex2_lsu with a behavioural memory responder whose
// ack delay and enable are set per step.
module tb_ex2_lsu;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] instr1 = '0, instr2 = '0;
  logic [31:0] addr1 = '0, addr2 = '0;
  logic [31:0] data1 = '0, data2 = '0;
  logic        busy;
  logic [31:0] ld1, ld2;
  logic        mis1, mis2, berr1, berr2;

  logic        ack_en = 1'b1;
  int          ack_wait = 0;
  logic [31:0] rdata_val = '0;
  int          wcnt;
  int          req_cycles = 0;
  int          tests = 0, fails = 0;
  int          r0;

  localparam logic [31:0] I_SB  = 32'h0000_0023;
  localparam logic [31:0] I_SW  = 32'h0000_2023;
  localparam logic [31:0] I_LB  = 32'h0000_0003;
  localparam logic [31:0] I_LH  = 32'h0000_1003;
  localparam logic [31:0] I_LW  = 32'h0000_2003;
  localparam logic [31:0] I_LHU = 32'h0000_5003;

  ex2_lsu_if mif ();

  ex2_lsu #(.TIMEOUT(4), .TO_W(3)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .EX2_in_instr1       (instr1),
    .EX2_in_instr2       (instr2),
    .EX2_in_alu_result1  (addr1),
    .EX2_in_alu_result2  (addr2),
    .EX2_in_read_data2_1 (data1),
    .EX2_in_read_data2_2 (data2),
    .mem                 (mif.master),
    .EX2_lsu_busy        (busy),
    .EX2_out_ld_data1    (ld1),
    .EX2_out_ld_data2    (ld2),
    .EX2_out_misalign1   (mis1),
    .EX2_out_misalign2   (mis2),
    .EX2_out_bus_err1    (berr1),
    .EX2_out_bus_err2    (berr2)
  );

  always #5 clk = ~clk;

  assign mif.mem_ack   = ack_en & mif.mem_req & (wcnt >= ack_wait);
  assign mif.mem_rdata = rdata_val;

  // Memory responder wait counter and request-cycle tally.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt <= 0;
    end else begin
      if (mif.mem_req && !mif.mem_ack) wcnt <= wcnt + 1;
      else                             wcnt <= 0;
      if (mif.mem_req) req_cycles <= req_cycles + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    instr1 = '0; instr2 = '0;
  endtask

  // Advance until busy drops (the DONE cycle), bounded.
  task automatic run_to_done(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (busy !== 1'b0 && n < 20);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $error("FAIL %s_timeout observed busy=%b expected=0", tag, busy);
    end
  endtask

  initial begin
    #12 rstn = 1'b1;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_req", {31'b0, mif.mem_req}, 32'd0);
    check("rst_ld1", ld1, 32'd0);
    check("rst_flags", {28'b0, mis1, mis2, berr1, berr2}, 32'd0);
    step();

    // SW 0x100, lane2 bubble, zero-wait ack
    r0 = req_cycles;
    instr1 = I_SW; addr1 = 32'h100; data1 = 32'hDEADBEEF;
    #1 check("sw_idle_busy", {31'b0, busy}, 32'd1);
    step();
    check("sw_req", {31'b0, mif.mem_req}, 32'd1);
    check("sw_we", {31'b0, mif.mem_we}, 32'd1);
    check("sw_addr", mif.mem_addr, 32'h100);
    check("sw_wdata", mif.mem_wdata, 32'hDEADBEEF);
    check("sw_wstrb", {28'b0, mif.mem_wstrb}, 32'hF);
    check("sw_acc_busy", {31'b0, busy}, 32'd1);
    step();
    check("sw_done_busy", {31'b0, busy}, 32'd0);
    check("sw_done_flags", {28'b0, mis1, mis2, berr1, berr2}, 32'd0);
    bubble();
    step();
    check("sw_req_count", req_cycles - r0, 32'd1);
    check("sw_idle_after", {31'b0, busy}, 32'd0);

    // SB 0x103 then LB 0x103
    rdata_val = 32'h5A000000;
    instr1 = I_SB; addr1 = 32'h103; data1 = 32'h0000005A;
    instr2 = I_LB; addr2 = 32'h103;
    step();
    check("sb_wstrb", {28'b0, mif.mem_wstrb}, 32'h8);
    check("sb_wdata", mif.mem_wdata, 32'h5A5A5A5A);
    check("sb_we", {31'b0, mif.mem_we}, 32'd1);
    step();
    check("lb_req", {31'b0, mif.mem_req}, 32'd1);
    check("lb_we", {31'b0, mif.mem_we}, 32'd0);
    check("lb_addr", mif.mem_addr, 32'h100);
    step();
    check("lb_done_busy", {31'b0, busy}, 32'd0);
    check("lb_ld2", ld2, 32'h0000005A);
    check("lb_ld1", ld1, 32'h0);
    bubble();
    step();

    // LH / LHU at 0x102
    rdata_val = 32'h80000000;
    instr1 = I_LH; addr1 = 32'h102;
    run_to_done("lh");
    check("lh_ld1", ld1, 32'hFFFF8000);
    bubble();
    step();
    instr1 = I_LHU; addr1 = 32'h102;
    run_to_done("lhu");
    check("lhu_ld1", ld1, 32'h00008000);
    bubble();
    step();

    // LW misaligned lane1, LW aligned lane2
    rdata_val = 32'h12345678;
    r0 = req_cycles;
    instr1 = I_LW; addr1 = 32'h101;
    instr2 = I_LW; addr2 = 32'h200;
    step();
    check("mis_acc1_req", {31'b0, mif.mem_req}, 32'd0);
    step();
    check("mis_acc2_addr", mif.mem_addr, 32'h200);
    step();
    check("mis_done_busy", {31'b0, busy}, 32'd0);
    check("mis_flags", {28'b0, mis1, mis2, berr1, berr2}, 32'b1000);
    check("mis_ld1", ld1, 32'h0);
    check("mis_ld2", ld2, 32'h12345678);
    check("mis_req_count", req_cycles - r0, 32'd1);
    bubble();
    step();

    // Timeout with ack never asserted
    ack_en = 1'b0;
    r0 = req_cycles;
    instr1 = I_LW; addr1 = 32'h300;
    run_to_done("to");
    check("to_req_count", req_cycles - r0, 32'd4);
    check("to_flags", {28'b0, mis1, mis2, berr1, berr2}, 32'b0010);
    check("to_ld1", ld1, 32'h0);
    bubble();
    step();
    check("to_idle_busy", {31'b0, busy}, 32'd0);
    check("to_idle_req", {31'b0, mif.mem_req}, 32'd0);

    // Async reset during ACC2 with 3-cycle ack delay
    ack_en = 1'b1; ack_wait = 3;
    instr1 = I_SW; addr1 = 32'h400; data1 = 32'h11111111;
    instr2 = I_LW; addr2 = 32'h404;
    repeat (5) step();
    check("rst_acc2_req", {31'b0, mif.mem_req}, 32'd1);
    check("rst_acc2_addr", mif.mem_addr, 32'h404);
    step();
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_req", {31'b0, mif.mem_req}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    bubble();
    ack_wait = 0;
    #3 rstn = 1'b1;
    step();
    check("rst_rel_busy", {31'b0, busy}, 32'd0);
    check("rst_rel_req", {31'b0, mif.mem_req}, 32'd0);
    instr1 = I_SW; addr1 = 32'h500; data1 = 32'h22222222;
    #1 check("post_idle_busy", {31'b0, busy}, 32'd1);
    step();
    check("post_addr", mif.mem_addr, 32'h500);
    step();
    check("post_done_busy", {31'b0, busy}, 32'd0);
    bubble();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
